// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall decode, exception-flush FSM with redirect PC, and a
// sticky stall watchdog. Define PIPE_CTRL_PERF_EN to add the stall and flush event counters.
module pipe_ctrl #(
  parameter int unsigned NSTAGE       = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_BASE     = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              excp_valid_i,
  input  logic [4:0]        excp_code_i,
  input  logic [31:0]       epc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              busy_o,
  output logic              wdog_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam logic [4:0]        ERET_CODE  = 5'h0E;
  localparam int unsigned       WDOG_W     = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = WDOG_W'(WDOG_LIMIT);
  localparam logic [3:0]        FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {StIdle, StFlush} state_t;

  state_t              r_state;
  logic                r_flush;
  logic                r_busy;
  logic [31:0]         r_new_pc;
  logic [3:0]          r_flush_cnt;
  logic [WDOG_W-1:0]   r_wdog_cnt;
  logic                r_wdog;
  logic [NSTAGE-1:0]   w_stall_dec;
  logic                w_any;
  logic [31:0]         w_target;

  // Thermometer decode: every stage at or below the highest requester stalls; bit 0 never
  // requests on its own.
  always_comb begin
    w_any       = 1'b0;
    w_stall_dec = '0;
    for (int j = NSTAGE - 1; j >= 1; j--) begin
      w_any          = w_any | stallreq_i[j];
      w_stall_dec[j] = w_any;
    end
    w_stall_dec[0] = w_any;
  end

  assign stall_o = (rst || (r_state != StIdle)) ? '0 : w_stall_dec;

  always_comb begin
    if (excp_code_i == ERET_CODE) begin
      w_target = epc_i;
    end else begin
      w_target = EXC_BASE + {25'd0, excp_code_i, 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_flush     <= 1'b0;
      r_busy      <= 1'b0;
      r_new_pc    <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (excp_valid_i) begin
            r_state     <= StFlush;
            r_flush     <= 1'b1;
            r_busy      <= 1'b1;
            r_new_pc    <= w_target;
            r_flush_cnt <= FLUSH_INIT;
          end
        end
        StFlush: begin
          // Exceptions arriving mid-flush are dropped; the redirect already in flight wins.
          if (r_flush_cnt == 4'd0) begin
            r_state <= StIdle;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o  = r_flush;
  assign busy_o   = r_busy;
  assign new_pc_o = r_new_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog     <= 1'b0;
    end else if (stall_o[0]) begin
      if (r_wdog_cnt != WDOG_MAX) begin
        r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
      end
      if (r_wdog_cnt >= (WDOG_MAX - WDOG_W'(1))) begin
        r_wdog <= 1'b1;
      end
    end else begin
      r_wdog_cnt <= '0;
    end
  end

  assign wdog_o = r_wdog;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_evt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt     <= '0;
      r_flush_evt_cnt <= '0;
    end else begin
      if (stall_o[0]) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((r_state == StIdle) && excp_valid_i) begin
        r_flush_evt_cnt <= r_flush_evt_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_evt_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance and one with a 3-cycle flush and a
// 4-cycle watchdog, both driven from the same stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        excp_valid;
  logic [4:0]  excp_code;
  logic [31:0] epc;

  logic [5:0]  stall_d, stall_f;
  logic        flush_d, flush_f, busy_d, busy_f, wdog_d, wdog_f;
  logic [31:0] newpc_d, newpc_f;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] scnt_d, scnt_f, fcnt_d, fcnt_f;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut_d (
    .clk          (clk),
    .rst          (rst),
    .stallreq_i   (stallreq),
    .excp_valid_i (excp_valid),
    .excp_code_i  (excp_code),
    .epc_i        (epc),
    .stall_o      (stall_d),
    .flush_o      (flush_d),
    .new_pc_o     (newpc_d),
    .busy_o       (busy_d),
    .wdog_o       (wdog_d)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o  (scnt_d),
    .flush_cnt_o  (fcnt_d)
`endif
  );

  pipe_ctrl #(
    .FLUSH_CYCLES (3),
    .WDOG_LIMIT   (4)
  ) dut_f (
    .clk          (clk),
    .rst          (rst),
    .stallreq_i   (stallreq),
    .excp_valid_i (excp_valid),
    .excp_code_i  (excp_code),
    .epc_i        (epc),
    .stall_o      (stall_f),
    .flush_o      (flush_f),
    .new_pc_o     (newpc_f),
    .busy_o       (busy_f),
    .wdog_o       (wdog_f)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o  (scnt_f),
    .flush_cnt_o  (fcnt_f)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    stallreq   = 6'b000100;
    excp_valid = 1'b0;
    excp_code  = 5'h00;
    epc        = 32'h0;
    #1;
    chk("rst_stall_d", {26'd0, stall_d}, 32'h0);
    chk("rst_stall_f", {26'd0, stall_f}, 32'h0);
    chk("rst_flush_d", {31'd0, flush_d}, 32'h0);
    chk("rst_busy_d",  {31'd0, busy_d},  32'h0);
    chk("rst_newpc_d", newpc_d,          32'h0);
    chk("rst_wdog_f",  {31'd0, wdog_f},  32'h0);
    stallreq = 6'b000000;
    tick();
    tick();
    rst = 1'b0;

    // Stall decode
    stallreq = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dec_0100_d", {26'd0, stall_d}, 32'h07);
      chk("dec_0100_f", {26'd0, stall_f}, 32'h07);
      tick();
    end
    stallreq = 6'b000000;
    #1;
    chk("dec_none_d", {26'd0, stall_d}, 32'h00);
    chk("wdog_f_3",   {31'd0, wdog_f},  32'h0);
    stallreq = 6'b001010;
    #1;
    chk("dec_1010_d", {26'd0, stall_d}, 32'h0F);
    chk("dec_1010_f", {26'd0, stall_f}, 32'h0F);
    stallreq = 6'b100000;
    #1;
    chk("dec_top_d", {26'd0, stall_d}, 32'h3F);
    stallreq = 6'b000001;
    #1;
    chk("dec_bit0_d", {26'd0, stall_d}, 32'h00);
    stallreq = 6'b000000;
    tick();

    // Watchdog on the limit-4 instance
    stallreq = 6'b000100;
    tick();
    tick();
    tick();
    chk("wdog_f_pre",  {31'd0, wdog_f},  32'h0);
    tick();
    chk("wdog_f_trip", {31'd0, wdog_f},  32'h1);
    chk("wdog_d_idle", {31'd0, wdog_d},  32'h0);
    chk("wdog_stall",  {26'd0, stall_f}, 32'h07);
    stallreq = 6'b000000;
    tick();
    stallreq = 6'b000100;
    tick();
    tick();
    stallreq = 6'b000000;
    #1;
    chk("wdog_sticky", {31'd0, wdog_f}, 32'h1);
    tick();

    // Exception code 8 with a simultaneous stall request
    excp_valid = 1'b1;
    excp_code  = 5'h08;
    stallreq   = 6'b000100;
    #1;
    chk("exc_pre_stall", {26'd0, stall_d}, 32'h07);
    tick();
    excp_valid = 1'b0;
    chk("exc_flush_d",  {31'd0, flush_d}, 32'h1);
    chk("exc_busy_d",   {31'd0, busy_d},  32'h1);
    chk("exc_newpc_d",  newpc_d,          32'h0000_0040);
    chk("exc_stall_d",  {26'd0, stall_d}, 32'h0);
    chk("exc_flush_f",  {31'd0, flush_f}, 32'h1);
    chk("exc_stall_f",  {26'd0, stall_f}, 32'h0);
    stallreq = 6'b000000;
    tick();
    chk("exc_end_flush_d", {31'd0, flush_d}, 32'h0);
    chk("exc_end_busy_d",  {31'd0, busy_d},  32'h0);
    chk("exc_c2_flush_f",  {31'd0, flush_f}, 32'h1);
    tick();
    chk("exc_c3_flush_f",  {31'd0, flush_f}, 32'h1);
    tick();
    chk("exc_end_flush_f", {31'd0, flush_f}, 32'h0);
    chk("exc_end_busy_f",  {31'd0, busy_f},  32'h0);
    chk("exc_hold_newpc_f", newpc_f,         32'h0000_0040);

    // eret, then a second exception while flushing
    excp_valid = 1'b1;
    excp_code  = 5'h0E;
    epc        = 32'h0000_1234;
    tick();
    excp_code = 5'h04;
    chk("eret_newpc_d", newpc_d,          32'h0000_1234);
    chk("eret_newpc_f", newpc_f,          32'h0000_1234);
    chk("eret_flush_f", {31'd0, flush_f}, 32'h1);
    tick();
    excp_valid = 1'b0;
    chk("eret_c2_flush_d", {31'd0, flush_d}, 32'h0);
    chk("eret_c2_newpc_d", newpc_d,          32'h0000_1234);
    chk("eret_c2_flush_f", {31'd0, flush_f}, 32'h1);
    chk("eret_c2_newpc_f", newpc_f,          32'h0000_1234);
    tick();
    chk("eret_c3_flush_f", {31'd0, flush_f}, 32'h1);
    tick();
    chk("eret_end_flush_f", {31'd0, flush_f}, 32'h0);
    chk("eret_end_newpc_f", newpc_f,          32'h0000_1234);

    // Reset during the second flush cycle
    excp_valid = 1'b1;
    excp_code  = 5'h1F;
    tick();
    excp_valid = 1'b0;
    chk("c1f_newpc_f", newpc_f,          32'h0000_009C);
    chk("c1f_flush_f", {31'd0, flush_f}, 32'h1);
    tick();
    #2;
    rst      = 1'b1;
    stallreq = 6'b001010;
    #1;
    chk("mid_rst_flush_f", {31'd0, flush_f}, 32'h0);
    chk("mid_rst_busy_f",  {31'd0, busy_f},  32'h0);
    chk("mid_rst_newpc_f", newpc_f,          32'h0);
    chk("mid_rst_wdog_f",  {31'd0, wdog_f},  32'h0);
    chk("mid_rst_stall_f", {26'd0, stall_f}, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall_f", {26'd0, stall_f}, 32'h0F);
    chk("post_rst_stall_d", {26'd0, stall_d}, 32'h0F);
    stallreq = 6'b000000;
    tick();

`ifdef PIPE_CTRL_PERF_EN
    stallreq = 6'b000100;
    repeat (5) tick();
    stallreq = 6'b000000;
    #1;
    chk("perf_scnt_d", scnt_d, 32'd5);
    chk("perf_scnt_f", scnt_f, 32'd5);
    for (int e = 0; e < 2; e++) begin
      excp_valid = 1'b1;
      excp_code  = 5'h08;
      tick();
      excp_valid = 1'b0;
      repeat (4) tick();
    end
    chk("perf_fcnt_d", fcnt_d, 32'd2);
    chk("perf_fcnt_f", fcnt_f, 32'd2);
    chk("perf_scnt_hold", scnt_d, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
